dualram_writer: RTL and testbench
=================================

Name: dualram_writer

Overview:
- Producer-side fill controller for the two-bank dualram buffer.
- Accepts a valid/ready stream of 64-bit words with byte enables and writes them sequentially into the current write bank.
- When the bank is full or a burst ends, it hands the bank to the reader by toggling rnw.
- It stalls the stream when the reader has not released the previously handed bank.

Parameters:
DW, 64, data width
AW, 3, word address width; bank depth = 2**AW = 8
BEW, DW/8, byte-enable width

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  input beat valid
s_ready  out  1  controller can accept a beat
s_data  in  DW  input word
s_be  in  BEW  input byte enables
s_last  in  1  final beat of burst; forces early hand-over
wa  out  AW  RAM write address
di  out  DW  RAM write data
be  out  BEW  RAM write byte enables
di_valid  out  1  RAM write strobe
rnw  out  1  bank-select level to the RAM pair; toggles on each hand-over
rd_done  in  1  single-cycle pulse: reader has finished with the handed bank
bank_ready  out  1  single-cycle pulse on hand-over
bank_count  out  AW+1  number of words in the handed bank (1..8)

Behaviour:
- Reset (rst_n low, asynchronous) and the values held until the first edge after release:
  - state = FILL, wptr = 0, read_busy = 0.
  - wa = 0, di = 0, be = 0, di_valid = 0, rnw = 0, bank_ready = 0, bank_count = 0.
  - s_ready = 1 once reset is released.
- Reset mid-operation: any partially filled bank is discarded and no bank_ready is issued.
- All outputs are registered. s_ready is decoded from state only: 1 in FILL, 0 in SWAP.
- Acceptance occurs on an edge where s_valid && s_ready.
  - On the following cycle: di_valid = 1, wa = wptr, di = s_data, be = s_be.
  - di_valid is otherwise 0. Latency is 1 cycle.
- A beat with s_be = 0 is still accepted. It consumes an address, and di_valid is asserted with be = 0.
- wptr increments on each accept. It wraps to 0 only through a hand-over, never by overflow.
- Completion: an accept with wptr == 2**AW-1 or s_last = 1 moves FILL -> SWAP. The completing word count (wptr+1) is latched.
- SWAP state:
  - Entered the cycle the last write is on di_valid, so the RAM write completes before any bank switch.
  - Swap condition: !read_busy || rd_done. rd_done in the same cycle counts as release.
  - When the swap condition holds at an edge:
    - rnw toggles and bank_ready pulses for 1 cycle.
    - bank_count takes the latched count and holds until the next hand-over.
    - read_busy = 1, wptr = 0, state -> FILL.
  - Otherwise the block remains in SWAP with s_ready = 0 and does not time out.
- Minimum cost is one bubble cycle per bank: the best-case sustained rate is 8 words per 9 cycles.
- read_busy:
  - Set on hand-over; cleared by rd_done.
  - rd_done while read_busy = 0 is ignored.
  - rd_done on the same edge as a hand-over leaves read_busy = 1, because it releases the older bank.
- s_data, s_be and s_last are ignored when not accepted. s_last is meaningful only on an accepted beat.

Decomposition:
- Shared package dualram_pkg holds:
  - DW/AW/BEW defaults.
  - State enum {FILL, SWAP}.
  - The bank_count width constant, also used by the read-side consumer.
- No sub-module: a single flat module (state register, address counter, output register stage).

Test Plan:
- Full fill: 8 back-to-back beats, data 0x1000+i, be = 0xFF, rd_done never asserted.
  - wa steps 0..7 with di_valid.
  - Cycle after last write: rnw 0 -> 1, bank_ready pulse, bank_count = 8, s_ready returns to 1.
- Early burst end: 3 beats, s_last on beat 3.
  - Writes at wa 0..2, then hand-over with bank_count = 3.
  - Next accepted beat is written at wa = 0.
- Back-pressure: fill two banks without rd_done.
  - The second bank stays in SWAP with s_ready = 0 and rnw unchanged.
  - Pulse rd_done at cycle 20: rnw toggles that edge, bank_ready pulses, and filling resumes.
- Simultaneous release: rd_done asserted on the exact cycle SWAP is entered.
  - Hand-over happens with no extra stall, and read_busy remains 1 afterwards.
- Reset mid-fill: accept 5 beats, then pulse rst_n low asynchronously between edges.
  - All outputs are 0 immediately and rnw = 0.
  - No bank_ready is issued.
  - The next beat is written at wa = 0.
- Byte-enable and idle pass-through: beats with be = 0xA5 and be = 0x00 are written with identical be on the port.
  - s_valid gaps of 2 cycles produce di_valid = 0 gaps with wptr unchanged.

Source files
------------

// File: rtl/dualram_pkg.sv
// Shared definitions for the two-bank dualram buffer: default widths,
// writer FSM states and the bank word-count width seen by both sides.
package dualram_pkg;

    localparam int unsigned DW    = 64;
    localparam int unsigned AW    = 3;
    localparam int unsigned BEW   = DW / 8;
    localparam int unsigned DEPTH = 1 << AW;
    // bank_count must be able to represent a completely full bank (DEPTH)
    localparam int unsigned CNTW  = AW + 1;

    typedef enum logic {
        FILL = 1'b0,
        SWAP = 1'b1
    } state_e;

endpackage

// File: rtl/dualram_writer.sv
// Producer-side fill controller: writes a valid/ready beat stream into the
// current bank and hands the bank to the reader on full or burst end.
module dualram_writer
    import dualram_pkg::*;
#(
    parameter int unsigned DW  = dualram_pkg::DW,
    parameter int unsigned AW  = dualram_pkg::AW,
    parameter int unsigned BEW = DW / 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [DW-1:0]  s_data,
    input  logic [BEW-1:0] s_be,
    input  logic           s_last,
    output logic [AW-1:0]  wa,
    output logic [DW-1:0]  di,
    output logic [BEW-1:0] be,
    output logic           di_valid,
    output logic           rnw,
    input  logic           rd_done,
    output logic           bank_ready,
    output logic [AW:0]    bank_count
);

    state_e         state_q, state_d;
    logic [AW-1:0]  wptr_q, wptr_d;
    logic           read_busy_q, read_busy_d;
    logic [AW:0]    count_q, count_d;

    logic [AW-1:0]  wa_d;
    logic [DW-1:0]  di_d;
    logic [BEW-1:0] be_d;
    logic           di_valid_d;
    logic           rnw_d;
    logic           bank_ready_d;
    logic [AW:0]    bank_count_d;

    logic           accept;
    logic           handover;

    // s_ready depends on the state register alone, so it is glitch-free
    assign s_ready  = (state_q == FILL);
    assign accept   = (state_q == FILL) && s_valid;
    assign handover = (state_q == SWAP) && (!read_busy_q || rd_done);

    // Next-state and output decode
    always_comb begin
        state_d      = state_q;
        wptr_d       = wptr_q;
        read_busy_d  = read_busy_q;
        count_d      = count_q;
        wa_d         = wa;
        di_d         = di;
        be_d         = be;
        di_valid_d   = 1'b0;
        rnw_d        = rnw;
        bank_ready_d = 1'b0;
        bank_count_d = bank_count;

        if (accept) begin
            di_valid_d = 1'b1;
            wa_d       = wptr_q;
            di_d       = s_data;
            be_d       = s_be;
            // The last slot never increments, so wptr wraps only via hand-over
            if ((wptr_q == '1) || s_last) begin
                state_d = SWAP;
                count_d = (AW+1)'(wptr_q) + (AW+1)'(1);
            end else begin
                wptr_d = wptr_q + AW'(1);
            end
        end

        // rd_done on a hand-over edge releases the older bank; the new one stays busy
        if (handover) begin
            rnw_d        = ~rnw;
            bank_ready_d = 1'b1;
            bank_count_d = count_q;
            read_busy_d  = 1'b1;
            wptr_d       = '0;
            state_d      = FILL;
        end else if (rd_done) begin
            read_busy_d  = 1'b0;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            wptr_q      <= '0;
            read_busy_q <= 1'b0;
            count_q     <= '0;
            wa          <= '0;
            di          <= '0;
            be          <= '0;
            di_valid    <= 1'b0;
            rnw         <= 1'b0;
            bank_ready  <= 1'b0;
            bank_count  <= '0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            read_busy_q <= read_busy_d;
            count_q     <= count_d;
            wa          <= wa_d;
            di          <= di_d;
            be          <= be_d;
            di_valid    <= di_valid_d;
            rnw         <= rnw_d;
            bank_ready  <= bank_ready_d;
            bank_count  <= bank_count_d;
        end
    end

endmodule

// File: tb/tb_dualram_writer.sv
// Bench for dualram_writer: a bank-level model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_dualram_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [63:0] s_data = 64'h0;
    logic [7:0]  s_be = 8'h0;
    logic        s_last = 1'b0;
    logic [2:0]  wa;
    logic [63:0] di;
    logic [7:0]  be;
    logic        di_valid;
    logic        rnw;
    logic        rd_done = 1'b0;
    logic        bank_ready;
    logic [3:0]  bank_count;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    dualram_writer dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_be(s_be), .s_last(s_last),
        .wa(wa), .di(di), .be(be), .di_valid(di_valid),
        .rnw(rnw), .rd_done(rd_done), .bank_ready(bank_ready), .bank_count(bank_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the bank being filled is a queue of words; the reader holds at most one bank
    logic [63:0] q_bank[$];
    bit          m_fill = 1'b1;
    bit          reader_holds = 1'b0;
    logic [2:0]  e_wa = '0;
    logic [63:0] e_di = '0;
    logic [7:0]  e_be = '0;
    logic        e_dv = 1'b0;
    logic        e_rnw = 1'b0;
    logic        e_br = 1'b0;
    logic [3:0]  e_bc = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_bank.delete();
            m_fill <= 1'b1; reader_holds <= 1'b0;
            e_wa <= '0; e_di <= '0; e_be <= '0; e_dv <= 1'b0;
            e_rnw <= 1'b0; e_br <= 1'b0; e_bc <= '0;
        end else begin
            e_dv <= 1'b0;
            e_br <= 1'b0;
            if (!m_fill && (!reader_holds || rd_done)) begin
                e_rnw <= ~e_rnw;
                e_br <= 1'b1;
                e_bc <= 4'(q_bank.size());
                q_bank.delete();
                reader_holds <= 1'b1;
                m_fill <= 1'b1;
            end else begin
                if (rd_done) reader_holds <= 1'b0;
                if (m_fill && s_valid) begin
                    e_dv <= 1'b1;
                    e_wa <= 3'(q_bank.size());
                    e_di <= s_data;
                    e_be <= s_be;
                    q_bank.push_back(s_data);
                    if (q_bank.size() == 8 || s_last) m_fill <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_dv", 64'(di_valid), 64'(e_dv));
            chk("m_rnw", 64'(rnw), 64'(e_rnw));
            chk("m_bank_ready", 64'(bank_ready), 64'(e_br));
            chk("m_bank_count", 64'(bank_count), 64'(e_bc));
            chk("m_s_ready", 64'(s_ready), 64'(m_fill));
            if (e_dv) begin
                chk("m_wa", 64'(wa), 64'(e_wa));
                chk("m_di", di, e_di);
                chk("m_be", 64'(be), 64'(e_be));
            end
        end
    end

    // All driver tasks start and end 2 time units after a rising edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [63:0] d, input logic [7:0] b, input bit last);
        int n;
        bit ok;
        s_valid = 1'b1; s_data = d; s_be = b; s_last = last;
        n = 0; ok = 1'b0;
        while (!ok && n < 60) begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            n++;
        end
        #2;
        s_valid = 1'b0; s_last = 1'b0; s_data = 64'hBAD0_BAD0_BAD0_BAD0; s_be = 8'h3C;
        if (!ok) begin
            total++; bad++;
            $display("FAIL send_timeout: got s_ready=0 for %0d cycles want accept at %0t", n, $time);
        end
    endtask

    task automatic fill_bank(input logic [63:0] base);
        for (int i = 0; i < 8; i++) send(base + 64'(i), 8'hFF, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wa"}, 64'(wa), 64'd0);
        chk({tag, "_di"}, di, 64'd0);
        chk({tag, "_be"}, 64'(be), 64'd0);
        chk({tag, "_dv"}, 64'(di_valid), 64'd0);
        chk({tag, "_rnw"}, 64'(rnw), 64'd0);
        chk({tag, "_br"}, 64'(bank_ready), 64'd0);
        chk({tag, "_bc"}, 64'(bank_count), 64'd0);
    endtask

    initial begin
        #12;
        chk_all_zero("reset");
        chk_en = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b1;
        step();
        chk("reset_s_ready", 64'(s_ready), 64'd1);

        // Full fill, no rd_done
        fill_bank(64'h1000);
        @(negedge clk);
        chk("full_last_wa", 64'(wa), 64'd7);
        chk("full_last_di", di, 64'h1007);
        chk("full_swap_s_ready", 64'(s_ready), 64'd0);
        step();
        @(negedge clk);
        chk("full_rnw", 64'(rnw), 64'd1);
        chk("full_bank_ready", 64'(bank_ready), 64'd1);
        chk("full_bank_count", 64'(bank_count), 64'd8);
        chk("full_s_ready_back", 64'(s_ready), 64'd1);
        step();

        // Early burst end after release of the first bank
        rd_done = 1'b1; step(); rd_done = 1'b0;
        send(64'h2000, 8'hFF, 1'b0);
        send(64'h2001, 8'hFF, 1'b0);
        send(64'h2002, 8'hFF, 1'b1);
        @(negedge clk);
        chk("early_last_wa", 64'(wa), 64'd2);
        step();
        @(negedge clk);
        chk("early_bank_count", 64'(bank_count), 64'd3);
        chk("early_rnw", 64'(rnw), 64'd0);
        chk("early_bank_ready", 64'(bank_ready), 64'd1);
        step();
        send(64'h2100, 8'hFF, 1'b0);
        @(negedge clk);
        chk("early_restart_wa", 64'(wa), 64'd0);
        step();

        // Back-pressure: second bank waits for rd_done
        do_reset();
        fill_bank(64'h3000);
        fill_bank(64'h3100);
        repeat (3) step();
        @(negedge clk);
        chk("bp_stall_s_ready", 64'(s_ready), 64'd0);
        chk("bp_stall_rnw", 64'(rnw), 64'd1);
        step();
        rd_done = 1'b1; step(); rd_done = 1'b0;
        @(negedge clk);
        chk("bp_release_rnw", 64'(rnw), 64'd0);
        chk("bp_release_br", 64'(bank_ready), 64'd1);
        step();
        send(64'h3200, 8'hFF, 1'b0);
        @(negedge clk);
        chk("bp_resume_wa", 64'(wa), 64'd0);
        step();

        // Simultaneous release on the cycle SWAP is entered
        do_reset();
        fill_bank(64'h4000);
        fill_bank(64'h4100);
        rd_done = 1'b1; step(); rd_done = 1'b0;
        @(negedge clk);
        chk("sim_bank_ready", 64'(bank_ready), 64'd1);
        chk("sim_rnw", 64'(rnw), 64'd0);
        step();
        send(64'h4200, 8'hFF, 1'b0);
        send(64'h4201, 8'hFF, 1'b1);
        repeat (3) step();
        @(negedge clk);
        chk("sim_still_busy", 64'(s_ready), 64'd0);
        step();
        rd_done = 1'b1; step(); rd_done = 1'b0;
        step();

        // Reset mid-fill after one hand-over
        do_reset();
        fill_bank(64'h5000);
        for (int i = 0; i < 5; i++) send(64'h5100 + 64'(i), 8'hFF, 1'b0);
        #1 rst_n = 1'b0;
        #1 chk_all_zero("midrst");
        step();
        rst_n = 1'b1;
        step(); step();
        send(64'h5200, 8'h0F, 1'b0);
        @(negedge clk);
        chk("midrst_next_wa", 64'(wa), 64'd0);
        chk("midrst_next_be", 64'(be), 64'h0F);
        step();

        // Byte-enable pass-through and idle gaps
        do_reset();
        send(64'h6000, 8'hA5, 1'b0);
        @(negedge clk);
        chk("be_a5", 64'(be), 64'hA5);
        step();
        @(negedge clk);
        chk("gap1_dv", 64'(di_valid), 64'd0);
        step();
        @(negedge clk);
        chk("gap2_dv", 64'(di_valid), 64'd0);
        step();
        send(64'h6001, 8'h00, 1'b0);
        @(negedge clk);
        chk("be_zero", 64'(be), 64'd0);
        chk("be_zero_dv", 64'(di_valid), 64'd1);
        chk("be_zero_wa", 64'(wa), 64'd1);
        step();
        step(); step();
        send(64'h6002, 8'hFF, 1'b1);
        @(negedge clk);
        chk("gap_last_wa", 64'(wa), 64'd2);
        step();
        @(negedge clk);
        chk("gap_bank_count", 64'(bank_count), 64'd3);
        step(); step();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish by %0t", $time);
        $fatal(1);
    end

endmodule
